// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared constants for the pipelined carry-lookahead adder.
//   GROUP_W : bits handled per pipeline stage (one 4-bit lookahead group)
//   OP_ADD  : value of the 'sub' mode bit selecting addition
//   OP_SUB  : value of the 'sub' mode bit selecting subtraction
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int   GROUP_W = 4;
  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;

endpackage : cla_pkg

// File: rtl/cla_group4.sv
// ---------------------------------------------------------------------------
// cla_group4
// Purely combinational 4-bit carry-lookahead group.
//   a[3:0], b[3:0] : operand slices (b already inverted for subtraction)
//   ci             : carry into bit 0 of the group
//   s[3:0]         : sum slice
//   co             : carry out of bit 3
//   gg, gp         : group generate / group propagate
// ---------------------------------------------------------------------------
module cla_group4
  import cla_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               ci,
  output logic [GROUP_W-1:0] s,
  output logic               co,
  output logic               gg,
  output logic               gp
);

  logic [GROUP_W-1:0] g;
  logic [GROUP_W-1:0] p;
  logic [GROUP_W-1:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    // Every internal carry is expanded directly from ci so no ripple path exists.
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp = &p;
    co = gg | (gp & ci);

    s = p ^ c;
  end

endmodule : cla_group4

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined add/subtract unit. The operation is split into N = WIDTH/4
// groups; stage k resolves group k with a 4-bit lookahead block, using the
// carry registered by stage k-1. Operands, mode and the growing partial sum
// travel with the beat, so latency is N cycles at one beat per cycle.
// Flow control is a single global stall: every stage shifts only when the
// output register is empty or being taken.
//
// Optional build macro:
//   CLA_PIPE_SAT_EN : when defined, s saturates on two's-complement overflow
//                     (0x7F..F for positive a, 0x80..0 for negative a).
//                     cout and ovf are identical in both builds.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready is combinational)
//   a, b, cin, sub      : operands, carry-in (add only), mode (1 = subtract)
//   out_valid, out_ready: result handshake
//   s, cout, ovf        : result, MSB carry-out (1 = no borrow on subtract),
//                         signed overflow
// ---------------------------------------------------------------------------
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int N = WIDTH / GROUP_W;

  // Everything a beat needs to finish its remaining groups.
  // b is carried raw; the inversion for subtraction is reapplied per stage.
  typedef struct packed {
    logic             valid;
    logic             sub;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_t;

  stage_t stg_q [N];
  logic   advance;

  assign advance  = !stg_q[N-1].valid | out_ready;
  // The pipeline is being emptied while rst is high, so it can always take a beat.
  assign in_ready = advance | rst;

  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    stage_t             stg_in;
    stage_t             stg_d;
    logic [GROUP_W-1:0] b_eff;
    logic [GROUP_W-1:0] grp_s;
    logic               grp_co;
    logic               grp_gg;
    logic               grp_gp;
    logic               unused_grp_sig;

    if (gi == 0) begin : g_head
      // Stage 0 takes its beat straight from the ports. When no beat is
      // offered, valid=0 loads a bubble. Subtraction forces the +1 via ci.
      always_comb begin
        stg_in       = '0;
        stg_in.valid = in_valid;
        stg_in.sub   = sub;
        stg_in.carry = (sub == OP_SUB) ? 1'b1 : cin;
        stg_in.a     = a;
        stg_in.b     = b;
      end
    end else begin : g_body
      assign stg_in = stg_q[gi-1];
    end

    assign b_eff = stg_in.b[gi*GROUP_W +: GROUP_W] ^ {GROUP_W{stg_in.sub}};

    cla_group4 u_group (
      .a  (stg_in.a[gi*GROUP_W +: GROUP_W]),
      .b  (b_eff),
      .ci (stg_in.carry),
      .s  (grp_s),
      .co (grp_co),
      .gg (grp_gg),
      .gp (grp_gp)
    );

    // Group generate/propagate are only needed for a multi-level lookahead;
    // a one-group-per-stage pipeline consumes the carry-out alone.
    assign unused_grp_sig = grp_gg ^ grp_gp;

    // Only this stage's slice is written; earlier groups pass through untouched.
    always_comb begin
      stg_d                              = stg_in;
      stg_d.sum[gi*GROUP_W +: GROUP_W]   = grp_s;
      stg_d.carry                        = grp_co;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stg_q[gi] <= '0;
      end else if (advance) begin
        stg_q[gi] <= stg_d;
      end
    end
  end

  // Output side: everything is derived from the last stage register, so the
  // result stays frozen while the consumer stalls.
  logic b_eff_msb;

  assign out_valid = stg_q[N-1].valid;
  assign cout      = stg_q[N-1].carry;
  assign b_eff_msb = stg_q[N-1].b[WIDTH-1] ^ stg_q[N-1].sub;
  assign ovf       = (stg_q[N-1].a[WIDTH-1] == b_eff_msb) &
                     (stg_q[N-1].sum[WIDTH-1] != stg_q[N-1].a[WIDTH-1]);

`ifdef CLA_PIPE_SAT_EN
  always_comb begin
    s = stg_q[N-1].sum;
    if (ovf) begin
      // Overflow can only happen when both effective operands share a's sign.
      s = stg_q[N-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign s = stg_q[N-1].sum;
`endif

endmodule : cla_pipe_adder

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
// Directed, table-driven bench for cla_pipe_adder at WIDTH=16 (N=4).
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected s for an overflowing vector depends on the build.
  function automatic logic [W-1:0] sat_exp(input logic [W-1:0] wrapped, input logic a_msb);
`ifdef CLA_PIPE_SAT_EN
    return a_msb ? 16'h8000 : 16'h7FFF;
`else
    if (a_msb === 1'bx) return 16'hxxxx;
    return wrapped;
`endif
  endfunction

  task automatic drive(input vec_t v, input logic vld);
    in_valid = vld;
    a        = v.a;
    b        = v.b;
    cin      = v.cin;
    sub      = v.sub;
  endtask

  // One isolated beat: accept, measure latency, compare result.
  task automatic run_one(input int idx);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    drive(tbl[idx], 1'b1);
    #1;
    chk("one_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("one_latency", lat, LAT);
    chk("one_s", s, tbl[idx].s);
    chk("one_cout", cout, tbl[idx].cout);
    chk("one_ovf", ovf, tbl[idx].ovf);
    $display("txn %0d a=%h b=%h cin=%0d sub=%0d -> s=%h cout=%0d ovf=%0d lat=%0d",
             idx, tbl[idx].a, tbl[idx].b, tbl[idx].cin, tbl[idx].sub, s, cout, ovf, lat);
  endtask

  initial begin
    int           sent;
    int           got;
    logic [W-1:0] held_s;
    logic         ghost;

    //          a         b         cin   sub   s                          cout  ovf
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000,                  1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, sat_exp(16'h8000, 1'b0),  1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE,                  1'b0, 1'b0};
    tbl[3] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556,                  1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, sat_exp(16'h7FFF, 1'b1),  1'b1, 1'b1};
    tbl[5] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000,                  1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, sat_exp(16'h0000, 1'b1),  1'b1, 1'b1};
    tbl[7] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001,                  1'b0, 1'b0};
    tbl[8] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF,                  1'b0, 1'b0};
    tbl[9] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE,                  1'b0, 1'b0};

    // Reset state.
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Isolated beats from the table.
    for (int i = 0; i < 10; i++) run_one(i);

    // Eight back-to-back beats, consumer stalls in cycles 5..7.
    sent = 0;
    got  = 0;
    held_s = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) drive(tbl[sent], 1'b1);
      else          in_valid = 1'b0;
      #1;
      chk("stream_in_ready", in_ready, out_ready);
      if (!out_ready) begin
        chk("stall_out_valid", out_valid, 1);
        if (cyc > 5) chk("stall_hold_s", s, held_s);
        held_s = s;
      end
      if (out_valid && out_ready) begin
        if (got < 8) begin
          chk("stream_s", s, tbl[got].s);
          chk("stream_cout", cout, tbl[got].cout);
          chk("stream_ovf", ovf, tbl[got].ovf);
          $display("txn stream %0d s=%h cout=%0d ovf=%0d cyc=%0d", got, s, cout, ovf, cyc);
        end else begin
          chk("stream_extra_beat", got + 1, 8);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    chk("stream_count", got, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with two beats in flight.
    @(negedge clk);
    drive(tbl[0], 1'b1);
    @(negedge clk);
    drive(tbl[3], 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    rst = 1'b0;
    ghost = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    chk("midrst_no_ghost", ghost, 0);
    $display("txn reset_flush ghost=%0d", ghost);
    run_one(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cla_pipe_adder
